// File: rtl/y86_seq_ctrl_if.sv
// Control/datapath bundle between the SEQ sequencer and the Y86-64 datapath stages.
interface y86_seq_ctrl_if #(
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 run;
  logic                 step;
  logic [3:0]           icode;
  logic                 cnd;
  logic                 instr_valid;
  logic                 imem_error;
  logic                 hlt_in;
  logic                 mem_ready;
  logic                 dmem_error;
  logic [PC_WIDTH-1:0]  valC;
  logic [PC_WIDTH-1:0]  valM;
  logic [PC_WIDTH-1:0]  valP;
  logic [PC_WIDTH-1:0]  pc;
  logic                 fetch_en;
  logic                 dec_en;
  logic                 exe_en;
  logic                 mem_en;
  logic                 wb_en;
  logic                 pc_en;
  logic [2:0]           stat;
  logic                 busy;
  logic                 limit_hit;
  logic [CNT_WIDTH-1:0] instr_count;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    input  run, step, icode, cnd, instr_valid, imem_error, hlt_in,
           mem_ready, dmem_error, valC, valM, valP,
    output pc, fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en,
           stat, busy, limit_hit, instr_count, cycle_count
  );

  modport slave (
    output run, step, icode, cnd, instr_valid, imem_error, hlt_in,
           mem_ready, dmem_error, valC, valM, valP,
    input  pc, fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en,
           stat, busy, limit_hit, instr_count, cycle_count
  );
endinterface

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle SEQ Y86-64 sequencer: owns PC and status, issues one phase strobe per cycle.
module y86_seq_ctrl #(
  parameter int unsigned          PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          CNT_WIDTH = 32,
  parameter int unsigned          MAX_INSTR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  y86_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB, PCUP, STOP
  } state_t;

  localparam logic [2:0]           STAT_AOK = 3'd1;
  localparam logic [2:0]           STAT_HLT = 3'd2;
  localparam logic [2:0]           STAT_ADR = 3'd3;
  localparam logic [2:0]           STAT_INS = 3'd4;
  localparam logic [3:0]           I_JXX    = 4'd7;
  localparam logic [3:0]           I_CALL   = 4'd8;
  localparam logic [3:0]           I_RET    = 4'd9;
  localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;
  localparam logic [CNT_WIDTH-1:0] LIMIT    = CNT_WIDTH'(MAX_INSTR);

  state_t               state, state_nxt;
  logic [PC_WIDTH-1:0]  pc_q, pc_nxt;
  logic [2:0]           stat_q, stat_nxt;
  logic                 limit_q, limit_nxt;
  logic [CNT_WIDTH-1:0] icnt_q, icnt_nxt;
  logic [CNT_WIDTH-1:0] ccnt_q, ccnt_nxt;
  logic [5:0]           strobe_q;
  logic                 busy_q;

  // Next-state, architectural state update and counter logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    stat_nxt  = stat_q;
    limit_nxt = limit_q;
    icnt_nxt  = icnt_q;
    ccnt_nxt  = ccnt_q;

    if (state != IDLE && state != STOP && ccnt_q != CNT_SAT)
      ccnt_nxt = ccnt_q + CNT_WIDTH'(1);

    case (state)
      IDLE:    if (bus.run || bus.step) state_nxt = FETCH;
      FETCH: begin
        if (bus.imem_error) begin
          stat_nxt  = STAT_ADR;
          state_nxt = STOP;
        end else if (!bus.instr_valid) begin
          stat_nxt  = STAT_INS;
          state_nxt = STOP;
        end else if (bus.hlt_in) begin
          stat_nxt  = STAT_HLT;
          state_nxt = STOP;
        end else begin
          state_nxt = DECODE;
        end
      end
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: state_nxt = MEMORY;
      MEMORY: begin
        if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            stat_nxt  = STAT_ADR;
            state_nxt = STOP;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB:      state_nxt = PCUP;
      PCUP: begin
        case (bus.icode)
          I_CALL:  pc_nxt = bus.valC;
          I_JXX:   pc_nxt = bus.cnd ? bus.valC : bus.valP;
          I_RET:   pc_nxt = bus.valM;
          default: pc_nxt = bus.valP;
        endcase
        if (icnt_q != CNT_SAT) icnt_nxt = icnt_q + CNT_WIDTH'(1);
        if (MAX_INSTR != 0 && icnt_nxt == LIMIT) begin
          limit_nxt = 1'b1;
          state_nxt = STOP;
        end else if (bus.run) begin
          state_nxt = FETCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      STOP:    state_nxt = STOP;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and busy are registered from the next state so they stay one-hot with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      stat_q   <= STAT_AOK;
      limit_q  <= 1'b0;
      icnt_q   <= '0;
      ccnt_q   <= '0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      stat_q   <= stat_nxt;
      limit_q  <= limit_nxt;
      icnt_q   <= icnt_nxt;
      ccnt_q   <= ccnt_nxt;
      strobe_q <= {state_nxt == FETCH, state_nxt == DECODE, state_nxt == EXECUTE,
                   state_nxt == MEMORY, state_nxt == WB, state_nxt == PCUP};
      busy_q   <= (state_nxt != IDLE) && (state_nxt != STOP);
    end
  end

  assign bus.pc          = pc_q;
  assign bus.stat        = stat_q;
  assign bus.limit_hit   = limit_q;
  assign bus.instr_count = icnt_q;
  assign bus.cycle_count = ccnt_q;
  assign bus.busy        = busy_q;
  assign bus.fetch_en    = strobe_q[5];
  assign bus.dec_en      = strobe_q[4];
  assign bus.exe_en      = strobe_q[3];
  assign bus.mem_en      = strobe_q[2];
  assign bus.wb_en       = strobe_q[1];
  assign bus.pc_en       = strobe_q[0];

endmodule

// File: doc/y86_seq_ctrl.md
Name: y86_seq_ctrl

Overview:
Multi-cycle control sequencer for the SEQ Y86-64 core. It owns the architectural PC and the processor status register, and steps each instruction through fetch/decode/execute/memory/writeback/PC-update by issuing one-cycle phase strobes to the existing datapath stages. It replaces free-running combinational PC feedback and ad-hoc status logic with a clocked FSM. The FSM adds run/single-step modes, a memory-stall handshake, fault stop, instruction/cycle counters and an optional instruction limit.

Parameters:
PC_WIDTH, 64, width of PC and of valC/valM/valP inputs
RESET_PC, 0, PC value loaded on reset
CNT_WIDTH, 32, width of instr_count and cycle_count
MAX_INSTR, 0, retire limit after which the core stops; 0 = unlimited

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; free-run enable
step  in  1  pulse; execute one instruction when idle
icode  in  4  decoded instruction code from fetch
cnd  in  1  branch/cmov condition from execute
instr_valid  in  1  1 = legal instruction
imem_error  in  1  instruction fetch address fault
hlt_in  in  1  fetched instruction is halt
mem_ready  in  1  data memory access complete
dmem_error  in  1  data memory address fault, valid with mem_ready
valC  in  PC_WIDTH  constant word
valM  in  PC_WIDTH  memory read value
valP  in  PC_WIDTH  incremented PC
pc  out  PC_WIDTH  current PC
fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en  out  1 each  phase strobes
stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
busy  out  1  instruction in flight
limit_hit  out  1  stopped by MAX_INSTR
instr_count  out  CNT_WIDTH  retired instructions
cycle_count  out  CNT_WIDTH  active cycles

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, stat=1, all strobes 0, busy 0, limit_hit 0, counters 0, state IDLE. Reset mid-instruction aborts immediately with no partial PC/stat update.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WB, PCUP, STOP.
- Strobes are Moore outputs, one-hot with state (fetch_en in FETCH … pc_en in PCUP). All strobes are 0 in IDLE and STOP.
- busy=1 in FETCH..PCUP.
- IDLE: on run=1 or step=1, go to FETCH. run and step together are treated as run. step outside IDLE is ignored.
- FETCH → DECODE, except when a fault is sampled at the edge leaving FETCH. Fault priority:
  - imem_error → stat=3
  - else !instr_valid → stat=4
  - else hlt_in → stat=2
  - On any fault go to STOP. pc keeps the faulting instruction address and instr_count is not incremented.
- DECODE → EXECUTE → MEMORY, one cycle each.
- MEMORY: mem_en is held until mem_ready=1 at an edge.
  - mem_ready with dmem_error → stat=3, go to STOP; wb_en is never issued.
  - mem_ready without dmem_error → WB.
- WB → PCUP.
- PCUP, at the exiting edge:
  - pc update: icode 8 → valC; icode 7 → cnd ? valC : valP; icode 9 → valM; all others → valP.
  - instr_count increments.
  - If MAX_INSTR≠0 and the new count equals MAX_INSTR: go to STOP, limit_hit=1, stat stays 1.
  - Else if run=1 → FETCH; else → IDLE.
- run deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- STOP: terminal until reset; run and step are ignored.
- Latency: 6 cycles per instruction with zero memory wait; each cycle mem_ready is low adds 1 cycle.
- cycle_count increments every cycle with busy=1.
- Both counters saturate at all-ones; no wrap.
- PC arithmetic is not performed here; values are taken as given at PC_WIDTH bits.

Test Plan:
- Step, nop: RESET_PC=0, icode=1, valP=1, mem_ready=1, one step pulse → strobes FETCH..PCUP on 6 consecutive cycles, then pc=1, instr_count=1, cycle_count=6, state IDLE, busy=0.
- Branch: run=1, icode=7, valP=0x0A, valC=0x40 → cnd=0 gives pc=0x0A; cnd=1 gives pc=0x40. icode=9 with valM=0x88 gives pc=0x88.
- Fetch fault: pc=0x20 with imem_error=1 → stat=3, pc stays 0x20, dec_en never asserted, stays in STOP with run=1. Repeat with instr_valid=0 → stat=4; with hlt_in=1 → stat=2, instr_count unchanged.
- Memory stall: mem_ready low for 3 cycles → mem_en high 4 cycles, 9 cycles for the instruction. mem_ready=1 with dmem_error=1 → stat=3, no wb_en or pc_en, pc unchanged.
- Limit: MAX_INSTR=3, run=1, nops → stops after 3rd PCUP, instr_count=3, limit_hit=1, stat=1, pc=3.
- Async reset asserted during EXECUTE between clock edges → all strobes 0 immediately, pc=RESET_PC, counters 0, stat=1. After release, run restarts from FETCH.
